// File: rtl/vote_tally_seq_pkg.sv
// Shared definitions for the serial vote tally: FSM states, count-width
// helper and the supported voter ceiling.
package vote_pkg;

  localparam int unsigned MAX_VOTERS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } vote_state_e;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vote_tally_seq_serial_counter.sv
// Serial popcount engine: captures a ballot, then consumes one voter bit per
// enabled cycle. yes_sum already includes the bit being consumed this cycle,
// so on the done cycle it is the final total.
// Optional feature macro: VOTE_TALLY_ABSTAIN_EN (adds a present mask and a
// second accumulator for the number of present voters).
module vote_serial_counter
  import vote_pkg::*;
#(
  parameter int unsigned N_VOTERS = 4,
  parameter int unsigned CNT_W    = cnt_width(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [N_VOTERS-1:0] ballot,
`ifdef VOTE_TALLY_ABSTAIN_EN
  input  logic [N_VOTERS-1:0] present,
  output logic [CNT_W-1:0]    pres_sum,
`endif
  output logic [CNT_W-1:0]    yes_sum,
  output logic                done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VOTERS - 1);

  logic [N_VOTERS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    yes_acc_q, yes_acc_d;
`ifdef VOTE_TALLY_ABSTAIN_EN
  logic [N_VOTERS-1:0] pshreg_q, pshreg_d;
  logic [CNT_W-1:0]    pres_acc_q, pres_acc_d;
`endif

  // Running totals including the bit at the head of the shift register.
  always_comb begin
    yes_sum = yes_acc_q + CNT_W'(shreg_q[0]);
`ifdef VOTE_TALLY_ABSTAIN_EN
    pres_sum = pres_acc_q + CNT_W'(pshreg_q[0]);
`endif
    done = en && (idx_q == LAST_IDX);
  end

  // Load / shift-and-accumulate next-state logic.
  always_comb begin
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    yes_acc_d = yes_acc_q;
`ifdef VOTE_TALLY_ABSTAIN_EN
    pshreg_d   = pshreg_q;
    pres_acc_d = pres_acc_q;
`endif
    if (load) begin
      // Absent voters are masked off at capture so the yes path never sees them.
`ifdef VOTE_TALLY_ABSTAIN_EN
      shreg_d    = ballot & present;
      pshreg_d   = present;
      pres_acc_d = '0;
`else
      shreg_d = ballot;
`endif
      idx_d     = '0;
      yes_acc_d = '0;
    end else if (en) begin
      shreg_d   = shreg_q >> 1;
      idx_d     = idx_q + CNT_W'(1);
      yes_acc_d = yes_sum;
`ifdef VOTE_TALLY_ABSTAIN_EN
      pshreg_d   = pshreg_q >> 1;
      pres_acc_d = pres_sum;
`endif
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      idx_q     <= '0;
      yes_acc_q <= '0;
`ifdef VOTE_TALLY_ABSTAIN_EN
      pshreg_q   <= '0;
      pres_acc_q <= '0;
`endif
    end else begin
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      yes_acc_q <= yes_acc_d;
`ifdef VOTE_TALLY_ABSTAIN_EN
      pshreg_q   <= pshreg_d;
      pres_acc_q <= pres_acc_d;
`endif
    end
  end

endmodule

// File: rtl/vote_tally_seq.sv
// Sequential vote tally: accepts a ballot over a valid/ready handshake,
// counts one voter per clock, and presents yes count plus majority/tie flags
// over a second valid/ready handshake.
// Optional feature macro: VOTE_TALLY_ABSTAIN_EN (present mask; denominator
// becomes the number of present voters).
module vote_tally_seq
  import vote_pkg::*;
#(
  parameter int unsigned N_VOTERS = 4,
  parameter int unsigned CNT_W    = cnt_width(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ballot_valid,
  output logic                ballot_ready,
  input  logic [N_VOTERS-1:0] ballot,
`ifdef VOTE_TALLY_ABSTAIN_EN
  input  logic [N_VOTERS-1:0] present,
`endif
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic                win,
  output logic                tie,
  output logic                busy
);

  vote_state_e state_q, state_d;

  logic [CNT_W-1:0] yes_cnt_q, yes_cnt_d;
  logic             win_q, win_d;
  logic             tie_q, tie_d;

  logic             load;
  logic             cnt_en;
  logic             cnt_done;
  logic [CNT_W-1:0] yes_sum;
  logic [CNT_W:0]   two_yes;
  logic [CNT_W:0]   denom;
  logic             win_nx;
  logic             tie_nx;
`ifdef VOTE_TALLY_ABSTAIN_EN
  logic [CNT_W-1:0] pres_sum;
`endif

  vote_serial_counter #(
    .N_VOTERS (N_VOTERS),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .en       (cnt_en),
    .ballot   (ballot),
`ifdef VOTE_TALLY_ABSTAIN_EN
    .present  (present),
    .pres_sum (pres_sum),
`endif
    .yes_sum  (yes_sum),
    .done     (cnt_done)
  );

  // FSM next state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    ballot_ready = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b0;
    load         = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        ballot_ready = 1'b1;
        if (ballot_valid) begin
          load    = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_done) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Majority / tie compare on the final count, one bit wider than the count.
  always_comb begin
    two_yes = {yes_sum, 1'b0};
`ifdef VOTE_TALLY_ABSTAIN_EN
    denom  = {1'b0, pres_sum};
    win_nx = two_yes > denom;
    tie_nx = (two_yes == denom) && (pres_sum != '0);
`else
    denom  = (CNT_W+1)'(N_VOTERS);
    win_nx = two_yes > denom;
    tie_nx = two_yes == denom;
`endif
  end

  // Result registers: updated only on the final count cycle, held otherwise.
  always_comb begin
    yes_cnt_d = yes_cnt_q;
    win_d     = win_q;
    tie_d     = tie_q;
    if (cnt_en && cnt_done) begin
      yes_cnt_d = yes_sum;
      win_d     = win_nx;
      tie_d     = tie_nx;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      yes_cnt_q <= '0;
      win_q     <= 1'b0;
      tie_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      yes_cnt_q <= yes_cnt_d;
      win_q     <= win_d;
      tie_q     <= tie_d;
    end
  end

  assign yes_cnt = yes_cnt_q;
  assign win     = win_q;
  assign tie     = tie_q;

endmodule

// File: tb/tb_vote_tally_seq.sv
// Self-checking bench for vote_tally_seq with N=4 and N=7 instances.
module tb_vote_tally_seq;

  localparam int N  = 4;
  localparam int W  = $clog2(N + 1);
  localparam int N7 = 7;
  localparam int W7 = $clog2(N7 + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic         bv = 1'b0, br, rv, rr = 1'b0, win, tie, busy;
  logic [N-1:0] ballot = '0;
  logic [N-1:0] present = '1;
  logic [W-1:0] yes;

  logic          bv7 = 1'b0, br7, rv7, rr7 = 1'b0, win7, tie7, busy7;
  logic [N7-1:0] ballot7 = '0;
  logic [N7-1:0] present7 = '1;
  logic [W7-1:0] yes7;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vote_tally_seq #(.N_VOTERS(N)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ballot_valid (bv),
    .ballot_ready (br),
    .ballot       (ballot),
`ifdef VOTE_TALLY_ABSTAIN_EN
    .present      (present),
`endif
    .res_valid    (rv),
    .res_ready    (rr),
    .yes_cnt      (yes),
    .win          (win),
    .tie          (tie),
    .busy         (busy)
  );

  vote_tally_seq #(.N_VOTERS(N7)) u_dut7 (
    .clk          (clk),
    .rst_n        (rst_n),
    .ballot_valid (bv7),
    .ballot_ready (br7),
    .ballot       (ballot7),
`ifdef VOTE_TALLY_ABSTAIN_EN
    .present      (present7),
`endif
    .res_valid    (rv7),
    .res_ready    (rr7),
    .yes_cnt      (yes7),
    .win          (win7),
    .tie          (tie7),
    .busy         (busy7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: yes = counted voters, denominator = number of voters present.
  function automatic int ref_yes(input logic [63:0] b, input logic [63:0] p);
    return $countones(b & p);
  endfunction
  function automatic bit ref_win(input logic [63:0] b, input logic [63:0] p);
    return 2 * $countones(b & p) > $countones(p);
  endfunction
  function automatic bit ref_tie(input logic [63:0] b, input logic [63:0] p);
    return (2 * $countones(b & p) == $countones(p)) && ($countones(p) != 0);
  endfunction

  // Full transaction on the N=4 instance; hold = cycles res_ready stays low in DONE.
  task automatic run4(input logic [N-1:0] b, input logic [N-1:0] p, input int hold);
    int lat;
    int ey;
    bit ew, et;
    logic [63:0] b64, p64;
    b64 = 64'(b);
`ifdef VOTE_TALLY_ABSTAIN_EN
    p64 = 64'(p);
`else
    p64 = 64'({N{1'b1}});
`endif
    ey = ref_yes(b64, p64);
    ew = ref_win(b64, p64);
    et = ref_tie(b64, p64);
    ballot  = b;
    present = p;
    bv      = 1'b1;
    chk("ready_idle", 32'(br), 32'd1);
    @(posedge clk); #1;
    bv     = 1'b0;
    ballot = ~b;
    lat    = 0;
    while (!rv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(N));
    chk("yes", 32'(yes), 32'(ey));
    chk("win", 32'(win), 32'(ew));
    chk("tie", 32'(tie), 32'(et));
    chk("busy_done", 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bv = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rv), 32'd1);
      chk("hold_ready", 32'(br), 32'd0);
      chk("hold_yes", 32'(yes), 32'(ey));
      chk("hold_flags", 32'({win, tie}), 32'({ew, et}));
    end
    bv = 1'b0;
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    chk("post_valid", 32'(rv), 32'd0);
    chk("post_ready", 32'(br), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_yes_held", 32'(yes), 32'(ey));
  endtask

  task automatic run7(input logic [N7-1:0] b);
    int lat;
    logic [63:0] b64, p64;
    b64 = 64'(b);
    p64 = 64'({N7{1'b1}});
    ballot7 = b;
    bv7     = 1'b1;
    @(posedge clk); #1;
    bv7 = 1'b0;
    lat = 0;
    while (!rv7 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n7_latency", 32'(lat), 32'(N7));
    chk("n7_yes", 32'(yes7), 32'(ref_yes(b64, p64)));
    chk("n7_win", 32'(win7), 32'(ref_win(b64, p64)));
    chk("n7_tie", 32'(tie7), 32'(ref_tie(b64, p64)));
    rr7 = 1'b1;
    @(posedge clk); #1;
    rr7 = 1'b0;
    chk("n7_post_ready", 32'(br7), 32'd1);
  endtask

  initial begin
    logic [N-1:0] rb, rp;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(br), 32'd1);
    chk("rst_valid", 32'(rv), 32'd0);
    chk("rst_outs", 32'({yes, win, tie, busy}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: 0111 -> yes 3, majority
    run4(4'b0111, 4'b1111, 0);
    chk("d0111", 32'({yes, win, tie}), 32'({3'd3, 1'b1, 1'b0}));

    // Exhaustive sweep of all 16 ballots
    for (int v = 0; v < 16; v++) begin
      run4(4'(v), 4'b1111, 0);
`ifndef VOTE_TALLY_ABSTAIN_EN
      if (v == 10) chk("d1010", 32'({yes, win, tie}), 32'({3'd2, 1'b0, 1'b1}));
      if (v == 1)  chk("d0001", 32'({yes, win, tie}), 32'({3'd1, 1'b0, 1'b0}));
      if (v == 15) chk("d1111", 32'({yes, win, tie}), 32'({3'd4, 1'b1, 1'b0}));
      if (v == 0)  chk("d0000", 32'({yes, win, tie}), 32'd0);
`endif
    end

    // Backpressure: result held 10 cycles with ballot_valid asserted
    run4(4'b1101, 4'b1111, 10);

    // Reset during the second COUNT cycle
    ballot = 4'b1111;
    bv     = 1'b1;
    @(posedge clk); #1;
    bv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({yes, win, tie, busy, rv}), 32'd0);
    chk("midrst_ready", 32'(br), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run4(4'b0011, 4'b1111, 0);
`ifndef VOTE_TALLY_ABSTAIN_EN
    chk("d0011", 32'({yes, win, tie}), 32'({3'd2, 1'b0, 1'b1}));
`endif

`ifdef VOTE_TALLY_ABSTAIN_EN
    run4(4'b1011, 4'b0011, 0);
    chk("ab_1011_0011", 32'({yes, win, tie}), 32'({3'd2, 1'b1, 1'b0}));
    run4(4'b1011, 4'b0000, 0);
    chk("ab_pres0", 32'({yes, win, tie}), 32'd0);
    run4(4'b0001, 4'b0011, 0);
    chk("ab_tie", 32'({yes, win, tie}), 32'({3'd1, 1'b0, 1'b1}));
`endif

    // Randomized ballots with random result backpressure
    for (int k = 0; k < 25; k++) begin
      rb = 4'($urandom);
      rp = 4'($urandom);
      run4(rb, rp, int'($urandom_range(0, 3)));
    end

    // N=7 instance
    run7(7'b1110001);
    run7(7'b0000111);
    run7(7'b0000000);
    run7(7'b1111111);
    for (int k = 0; k < 8; k++) run7(7'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
